// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Multi-cycle multiply/divide unit for the MIPS EX stage. Holds the
//            architectural HI/LO registers, produces mult/multu/div/divu
//            results after a fixed latency and services mthi/mtlo writes.
// Ports    : clk      - clock, all state changes on the rising edge
//            reset    - synchronous active-high reset
//            Start    - op request, sampled on the rising edge
//            MDOp_EX  - 5-bit op code (mult/multu/div/divu/mthi/mtlo)
//            A, B     - rs / rt operands
//            Busy     - high while a mult/div is in flight
//            Done     - one-cycle pulse when new HI/LO first become visible
//            HI, LO   - architectural HI/LO registers
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [4:0]  MDOp_EX,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        Busy,
   output logic        Done,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam logic [4:0] c_OP_MULT  = 5'd1;
   localparam logic [4:0] c_OP_MULTU = 5'd2;
   localparam logic [4:0] c_OP_DIV   = 5'd3;
   localparam logic [4:0] c_OP_DIVU  = 5'd4;
   localparam logic [4:0] c_OP_MTHI  = 5'd5;
   localparam logic [4:0] c_OP_MTLO  = 5'd6;

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   // Counter only ever holds latency-1, so $clog2(MAX_CYCLES) bits suffice.
   localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

   localparam logic [CNT_W-1:0] c_MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   logic [0:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_hi_n;
   logic [31:0]      r_lo_n;
   logic             r_pend_wr;
   logic [31:0]      r_hi;
   logic [31:0]      r_lo;
   logic             r_done;

   // ------------------------------------------------------------------------
   // Op decode
   // ------------------------------------------------------------------------
   logic w_is_mult;
   logic w_is_div;
   logic w_is_md;
   logic w_div_signed;

   assign w_is_mult    = (MDOp_EX == c_OP_MULT) || (MDOp_EX == c_OP_MULTU);
   assign w_is_div     = (MDOp_EX == c_OP_DIV)  || (MDOp_EX == c_OP_DIVU);
   assign w_is_md      = w_is_mult || w_is_div;
   assign w_div_signed = (MDOp_EX == c_OP_DIV);

   // ------------------------------------------------------------------------
   // Result arithmetic (evaluated from A/B at the accepting edge)
   // ------------------------------------------------------------------------
   logic [63:0] w_prod_s;
   logic [63:0] w_prod_u;

   // Operands widened to 64 bits so the low 64 bits of the product are exact.
   assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
   assign w_prod_u = {32'd0, A} * {32'd0, B};

   // Signed division is done on magnitudes and the signs re-applied, which
   // also yields 0x80000000 / -1 = 0x80000000 without a special case.
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [31:0] w_dvd;
   logic [31:0] w_dvs;
   logic [31:0] w_dvs_safe;
   logic [31:0] w_q_mag;
   logic [31:0] w_r_mag;
   logic [31:0] w_quot;
   logic [31:0] w_rem;

   assign w_a_mag    = A[31] ? (~A + 32'd1) : A;
   assign w_b_mag    = B[31] ? (~B + 32'd1) : B;
   assign w_dvd      = w_div_signed ? w_a_mag : A;
   assign w_dvs      = w_div_signed ? w_b_mag : B;
   // Divide-by-zero results are discarded; a divisor of 1 keeps the divider defined.
   assign w_dvs_safe = (w_dvs == 32'd0) ? 32'd1 : w_dvs;
   assign w_q_mag    = w_dvd / w_dvs_safe;
   assign w_r_mag    = w_dvd % w_dvs_safe;
   assign w_quot     = (w_div_signed && (A[31] ^ B[31])) ? (~w_q_mag + 32'd1) : w_q_mag;
   assign w_rem      = (w_div_signed && A[31]) ? (~w_r_mag + 32'd1) : w_r_mag;

   logic [31:0] w_res_hi;
   logic [31:0] w_res_lo;
   logic        w_res_wr;

   always_comb begin
      w_res_hi = 32'd0;
      w_res_lo = 32'd0;
      case (MDOp_EX)
         c_OP_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
         c_OP_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
         c_OP_DIV,
         c_OP_DIVU: begin
            w_res_hi = w_rem;
            w_res_lo = w_quot;
         end
         default: ;
      endcase
   end

   // A zero divisor still runs the full latency but leaves HI/LO untouched.
   assign w_res_wr = !(w_is_div && (B == 32'd0));

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   logic [0:0] w_state_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (Start && w_is_md)   w_state_nxt = S_RUN;
         S_RUN:  if (r_cnt == '0)        w_state_nxt = S_IDLE;
         default:                        w_state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: output / control decode
   // ------------------------------------------------------------------------
   logic w_accept;
   logic w_finish;
   logic w_move;

   always_comb begin
      w_accept = 1'b0;
      w_finish = 1'b0;
      w_move   = 1'b0;
      Busy     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_accept = Start && w_is_md;
            w_move   = Start;
         end
         S_RUN: begin
            Busy     = 1'b1;
            w_finish = (r_cnt == '0);
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath: counter, pending result, HI/LO, Done
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt     <= '0;
         r_hi_n    <= 32'd0;
         r_lo_n    <= 32'd0;
         r_pend_wr <= 1'b0;
         r_hi      <= 32'd0;
         r_lo      <= 32'd0;
         r_done    <= 1'b0;
      end else begin
         r_done <= w_finish;

         if (w_accept) begin
            r_cnt     <= w_is_mult ? c_MULT_LOAD : c_DIV_LOAD;
            r_hi_n    <= w_res_hi;
            r_lo_n    <= w_res_lo;
            r_pend_wr <= w_res_wr;
         end else if (Busy && (r_cnt != '0)) begin
            r_cnt <= r_cnt - c_CNT_ONE;
         end

         if (w_finish) begin
            if (r_pend_wr) begin
               r_hi <= r_hi_n;
               r_lo <= r_lo_n;
            end
         end else if (w_move) begin
            // Moves are only honoured in IDLE; w_move is never set in RUN.
            if (MDOp_EX == c_OP_MTHI) r_hi <= A;
            if (MDOp_EX == c_OP_MTLO) r_lo <= A;
         end
      end
   end

   assign Done = r_done;
   assign HI   = r_hi;
   assign LO   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Self-checking bench for muldiv_unit: directed vector table,
//            hand-written multi-cycle corner sequences and randomized ops
//            compared against an arithmetic reference model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk;
   logic        reset;
   logic        Start;
   logic [4:0]  MDOp_EX;
   logic [31:0] A;
   logic [31:0] B;
   logic        Busy;
   logic        Done;
   logic [31:0] HI;
   logic [31:0] LO;

   muldiv_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk     (clk),
      .reset   (reset),
      .Start   (Start),
      .MDOp_EX (MDOp_EX),
      .A       (A),
      .B       (B),
      .Busy    (Busy),
      .Done    (Done),
      .HI      (HI),
      .LO      (LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference architectural state
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference model: plain 64-bit arithmetic. cyc = latency, 0 = move, -1 = no-op.
   task automatic model_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int cyc);
      longint          sa, sb, q, r;
      longint unsigned ua, ub, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      cyc = -1;
      case (op)
         5'd1: begin p = longint'(sa * sb); {m_hi, m_lo} = p; cyc = MC; end
         5'd2: begin p = ua * ub;           {m_hi, m_lo} = p; cyc = MC; end
         5'd3: begin
            cyc = DC;
            if (b != 0) begin
               q = sa / sb; r = sa % sb;
               m_lo = q[31:0]; m_hi = r[31:0];
            end
         end
         5'd4: begin
            cyc = DC;
            if (b != 0) begin
               p = ua / ub; m_lo = p[31:0];
               p = ua % ub; m_hi = p[31:0];
            end
         end
         5'd5: begin m_hi = a; cyc = 0; end
         5'd6: begin m_lo = a; cyc = 0; end
         default: cyc = -1;
      endcase
   endtask

   // Issue one op from IDLE and check latency, Done pulse and HI/LO.
   task automatic apply(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int cyc);
      int n;
      @(negedge clk);
      Start = 1'b1; MDOp_EX = op; A = a; B = b;
      @(negedge clk);
      Start = 1'b0; MDOp_EX = 5'($urandom); A = $urandom; B = $urandom;
      if (cyc <= 0) begin
         check({tag, " busy"}, {63'd0, Busy}, 64'd0);
         check({tag, " done"}, {63'd0, Done}, 64'd0);
         check({tag, " hi"},   {32'd0, HI}, {32'd0, ehi});
         check({tag, " lo"},   {32'd0, LO}, {32'd0, elo});
      end else begin
         n = 0;
         while (Busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
         end
         check({tag, " busy_cycles"}, 64'(n), 64'(cyc));
         check({tag, " done"}, {63'd0, Done}, 64'd1);
         check({tag, " hi"},   {32'd0, HI}, {32'd0, ehi});
         check({tag, " lo"},   {32'd0, LO}, {32'd0, elo});
         @(negedge clk);
         check({tag, " done_drop"}, {63'd0, Done}, 64'd0);
      end
   endtask

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } vec_t;

   vec_t vecs[11];

   initial begin
      int cyc;
      int n;

      vecs[0]  = '{5'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, MC};
      vecs[1]  = '{5'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC};
      vecs[2]  = '{5'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DC};
      vecs[3]  = '{5'd4, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, DC};
      vecs[4]  = '{5'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC};
      vecs[5]  = '{5'd5, 32'h00000011, 32'h12345678, 32'h00000011, 32'h80000000, 0};
      vecs[6]  = '{5'd6, 32'h00000022, 32'h12345678, 32'h00000011, 32'h00000022, 0};
      vecs[7]  = '{5'd4, 32'h00000064, 32'h00000000, 32'h00000011, 32'h00000022, DC};
      vecs[8]  = '{5'd3, 32'h80000000, 32'h00000000, 32'h00000011, 32'h00000022, DC};
      vecs[9]  = '{5'd0, 32'hAAAAAAAA, 32'h55555555, 32'h00000011, 32'h00000022, -1};
      vecs[10] = '{5'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DC};

      // Reset held two cycles
      reset = 1'b1; Start = 1'b0; MDOp_EX = 5'd0; A = 32'd0; B = 32'd0;
      repeat (2) @(negedge clk);
      check("reset hi",   {32'd0, HI}, 64'd0);
      check("reset lo",   {32'd0, LO}, 64'd0);
      check("reset busy", {63'd0, Busy}, 64'd0);
      check("reset done", {63'd0, Done}, 64'd0);
      reset = 1'b0;

      // Idle with toggling operands and an op code but no Start
      for (int i = 0; i < 4; i++) begin
         A = $urandom; B = $urandom; MDOp_EX = 5'(i + 1);
         @(negedge clk);
         check("idle hi",   {32'd0, HI}, 64'd0);
         check("idle lo",   {32'd0, LO}, 64'd0);
         check("idle busy", {63'd0, Busy}, 64'd0);
      end

      // Directed vector table
      for (int i = 0; i < 11; i++) begin
         apply($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
               vecs[i].hi, vecs[i].lo, vecs[i].cyc);
      end
      m_hi = HI === 32'h00000001 ? 32'h00000001 : 32'h00000001;
      m_lo = 32'hFFFFFFFD;

      // Start + mtlo / mthi while running must be ignored
      @(negedge clk);
      Start = 1'b1; MDOp_EX = 5'd1; A = 32'd5; B = 32'd6;
      @(negedge clk);
      n = 0;
      while (Busy === 1'b1 && n < 200) begin
         if (n == 0)      begin Start = 1'b1; MDOp_EX = 5'd6; A = 32'hDEAD0001; end
         else if (n == 1) begin Start = 1'b1; MDOp_EX = 5'd5; A = 32'hDEAD0002; end
         else if (n == 2) begin Start = 1'b1; MDOp_EX = 5'd2; A = 32'h7; B = 32'h7; end
         else             Start = 1'b0;
         n++;
         @(negedge clk);
      end
      Start = 1'b0;
      check("midrun busy_cycles", 64'(n), 64'(MC));
      check("midrun done", {63'd0, Done}, 64'd1);
      check("midrun hi", {32'd0, HI}, 64'd0);
      check("midrun lo", {32'd0, LO}, 64'd30);
      @(negedge clk);
      check("midrun busy_after", {63'd0, Busy}, 64'd0);
      m_hi = 32'd0; m_lo = 32'd30;

      // Reset in the third busy cycle of a mult 3x4 aborts it
      Start = 1'b1; MDOp_EX = 5'd1; A = 32'd3; B = 32'd4;
      @(negedge clk);
      Start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort hi",   {32'd0, HI}, 64'd0);
      check("abort lo",   {32'd0, LO}, 64'd0);
      check("abort busy", {63'd0, Busy}, 64'd0);
      check("abort done", {63'd0, Done}, 64'd0);
      @(negedge clk);
      check("abort no_done", {63'd0, Done}, 64'd0);
      apply("after_abort", 5'd1, 32'd3, 32'd4, 32'd0, 32'd12, MC);

      // Reset wins over a simultaneous mthi
      Start = 1'b1; MDOp_EX = 5'd5; A = 32'h55; reset = 1'b1;
      @(negedge clk);
      Start = 1'b0; reset = 1'b0;
      check("reset_vs_start hi", {32'd0, HI}, 64'd0);
      check("reset_vs_start lo", {32'd0, LO}, 64'd0);
      m_hi = 32'd0; m_lo = 32'd0;

      // Randomized ops against the reference model
      for (int i = 0; i < 80; i++) begin
         logic [4:0]  op;
         logic [31:0] a, b;
         op = 5'($urandom_range(0, 9));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            2: b = 32'($urandom_range(1, 9)) ;
            3: a = 32'($urandom_range(0, 20));
            default: ;
         endcase
         model_op(op, a, b, cyc);
         apply($sformatf("rnd%0d_op%0d", i, op), op, a, b, m_hi, m_lo, cyc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle multiply/divide unit for the MIPS EX stage, the sequential counterpart to the single-cycle ALU. It accepts operands and an op code under a start handshake, holds the result in architectural HI/LO registers after a fixed latency, and drives `Busy` so hazard logic can stall `mfhi`/`mflo` and further mult/div instructions. It also services `mthi`/`mtlo` writes.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu` (≥1).
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu` (≥1).

- `clk`: input, 1 bit. Single clock; all state changes on the rising edge.
- `reset`: input, 1 bit. Synchronous, active-high.
- `Start`: input, 1 bit. Op request; sampled on the rising edge.
- `MDOp_EX`: input, 5 bits. Op code:
  - 00001 `mult`; 00010 `multu`; 00011 `div`; 00100 `divu`;
  - 00101 `mthi`; 00110 `mtlo`;
  - other codes are no-ops.
- `A`: input, 32 bits. rs operand (dividend/multiplicand; `mthi`/`mtlo` data).
- `B`: input, 32 bits. rt operand (divisor/multiplier).
- `Busy`: output, 1 bit. High while a mult/div is in flight.
- `Done`: output, 1 bit. One-cycle pulse in the first cycle new HI/LO are visible.
- `HI`: output, 32 bits. HI register (product high word / remainder).
- `LO`: output, 32 bits. LO register (product low word / quotient).

## Operation
- **States:**
  - IDLE: `Busy`=0.
  - RUN: `Busy`=1. Down-counter `cnt` and pending result `{hi_n, lo_n}` are held.
- **IDLE, `Start`=1 with a mult/div op:**
  - Latch the result computed from current A/B.
  - Load `cnt` = latency−1.
  - Go to RUN.
- **Result arithmetic:**
  - `mult`: signed 32×32 to 64-bit product `{HI,LO}`.
  - `multu`: unsigned 32×32 to 64-bit product `{HI,LO}`.
  - `div`: signed. Quotient truncates toward zero; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - `divu`: unsigned.
- **Divide by zero (B=0, `div`/`divu`):**
  - The op still runs `DIV_CYCLES` with `Busy` high.
  - HI/LO are left unchanged at completion.
  - `Done` still pulses.
- **RUN:**
  - `cnt` decrements each cycle.
  - When `cnt`=0: write `hi_n`/`lo_n` to HI/LO, return to IDLE, assert `Done` the next cycle.
- **`mthi`/`mtlo` with `Start`=1 in IDLE:**
  - HI (or LO) ← A on that edge.
  - `Busy` and `Done` are unaffected.
- **`Start` while in RUN:** ignored entirely, including `mthi`/`mtlo`. The upstream stall must prevent this; the unit does not queue.
- **`Start` with an undefined op:** no effect.
- **`reset`:**
  - Outputs after the edge: HI=0, LO=0, `Busy`=0, `Done`=0, state IDLE, `cnt`=0.
  - `reset` overrides `Start` on the same edge.
  - Reset during RUN aborts the op; the pending result is discarded.
- A and B need not be held after the `Start` edge.

## Timing
- **`Start` sampled at edge E0 (mult/div), latency N:**
  - `Busy`=1 from after E0 through after edge E(N−1).
  - HI/LO update at edge EN.
  - `Busy`=0 and `Done`=1 in the cycle after EN.
  - `Done` drops after E(N+1).
- A new `Start` is accepted at EN+1, i.e. back-to-back ops with one idle-visible cycle.
- `mthi`/`mtlo`: the value is visible one cycle after the `Start` edge.
- HI/LO never change except at:
  - completion,
  - an `mthi`/`mtlo` write,
  - reset.
- No combinational path from inputs to outputs.

## Test plan
- **Reset then idle:**
  - Hold `reset` 2 cycles → HI=LO=0, `Busy`=`Done`=0.
  - Toggle A/B with `Start`=0 → outputs unchanged.
- **Signed mult:**
  - A=0xFFFFFFFE (−2), B=0x00000003, `mult` → `Busy` high exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA with a 1-cycle `Done`.
- **Unsigned mult:** A=B=0xFFFFFFFF, `multu` → HI=0xFFFFFFFE, LO=0x00000001 after 5 busy cycles.
- **Division:**
  - `div` A=−7 (0xFFFFFFF9), B=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - `divu` same operands → LO=0x7FFFFFFC, HI=1.
  - `div` 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- **Edge cases:**
  - Preload HI=0x11, LO=0x22 via `mthi`/`mtlo`, then `divu` B=0 → 10 busy cycles, `Done` pulses, HI/LO stay 0x11/0x22.
  - Issue `Start`+`mtlo` mid-RUN → ignored.
- **Reset mid-operation:**
  - Start `mult` 3×4, assert `reset` on busy cycle 3 → HI=LO=0 and `Busy`=0 next cycle, no `Done`.
  - A following `mult` 3×4 → LO=12 after 5 cycles.
